bram_arbiter: RTL
=================

BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, RAM address width in bits.
REQ-002 SHALL have parameter DATA_W, default 16, RAM data width in bits.
REQ-003 SHALL have parameter BURST_MAX, default 4, max consecutive beats the owner keeps while the other requester waits.
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports a_req/b_req  in  1  access request.
REQ-007 SHALL have ports a_we/b_we  in  1  1 = write, 0 = read.
REQ-008 SHALL have ports a_addr/b_addr  in  ADDR_W  word address.
REQ-009 SHALL have ports a_wdata/b_wdata  in  DATA_W  write data.
REQ-010 SHALL have ports a_gnt/b_gnt  out  1  combinational acceptance; a beat transfers when req && gnt.
REQ-011 SHALL have ports a_rvalid/b_rvalid  out  1  one-cycle read-return strobe.
REQ-012 SHALL have ports a_rdata/b_rdata  out  DATA_W  read data, qualified by rvalid.
REQ-013 SHALL have ports ram_en, ram_we  out  1  registered RAM enable and write strobe.
REQ-014 SHALL have ports ram_addr  out  ADDR_W and ram_di  out  DATA_W  registered RAM address and write data.
REQ-015 SHALL have port ram_dout  in  DATA_W  from a single-port RAM with 1-cycle registered read latency, read-first.

Function
REQ-016 SHALL implement FSM states IDLE, OWN_A, OWN_B, plus register last (last owner) and beat counter cnt (range 1..BURST_MAX).
REQ-017 SHALL assert at most one of a_gnt/b_gnt in any cycle, and never assert gnt without the matching req.
REQ-018 In IDLE: one req -> grant it; both -> grant the one not equal to last; none -> stay IDLE.
REQ-019 In OWN_X: grant X while X_req && (!Y_req || cnt < BURST_MAX); each accepted beat increments cnt, saturating.
REQ-020 In OWN_X with Y_req && (!X_req || cnt == BURST_MAX): grant Y in the same cycle, next state OWN_Y, cnt = 1, last = Y; no dead cycle.
REQ-021 In OWN_X with no req: next state IDLE, last = X.
REQ-022 An accepted beat at cycle N SHALL drive ram_en=1, ram_we, ram_addr, ram_di in cycle N+1; with no beat, ram_en=0 and ram_we=0.
REQ-023 An accepted read at cycle N SHALL raise X_rvalid for exactly cycle N+2, with X_rdata = ram_dout; a 2-deep owner tag pipeline routes it.
REQ-024 X_rdata SHALL hold its last returned value when rvalid is low.
REQ-025 Writes SHALL produce no rvalid; back-to-back reads SHALL sustain 1 beat/cycle.
REQ-026 A read in cycle N+1 of an address written at N SHALL return the new data, since RAM accesses are serialized.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, last=B, cnt=1, tags cleared, ram_en=ram_we=0, ram_addr=ram_di=0, rvalid=0, rdata=0.
REQ-028 Reads in flight at reset SHALL be dropped with no rvalid after reset release; gnt is 0 while rst_n is low.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (IDLE/OWN_A/OWN_B) and the owner-ID type used by the tag pipeline.
REQ-030 The grant decision SHALL be one sub-module, rr_arb2 (combinational next-owner/gnt from state, last, cnt, reqs); sequencing and pipelines live in bram_arbiter.

Verification
REQ-031 Reset, then A writes 0x1234->addr 0x0010 and reads it -> ram_we at N+1; a_rvalid at read N+2, a_rdata=0x1234.
REQ-032 A and B req together from IDLE after reset -> A granted first (last=B).
REQ-033 A streams 10 reads, B requests from beat 1 -> A gets 4 beats, then B granted with no gap; A resumes after B drops or after 4 B beats.
REQ-034 A reads 0x0005 while B writes 0x0005=0xBEEF next cycle, then A reads again -> first read returns old value, second 0xBEEF.
REQ-035 rst_n pulsed low one cycle after two accepted reads -> ram_en=0 immediately, no rvalid ever seen for those reads.

Source files
------------

// File: rtl/bram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_arbiter_pkg
// Description : Shared types for the two-port BRAM arbiter. Holds the
//               ownership FSM state, the owner-ID type carried by the
//               read-return tag pipeline, and a counter-width helper.
// Revision    : 1.0  initial release
// ============================================================================
package bram_arbiter_pkg;

  // Ownership state of the shared RAM port
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_t;

  // Requester identity, used both for "last owner" and read-return routing
  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_t;

  // One stage of the read-return tag pipeline
  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rd_tag_t;

  // Bits needed to hold a beat count in the range 1..burst_max
  function automatic int cnt_width(input int burst_max);
    return (burst_max < 2) ? 1 : $clog2(burst_max + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bram_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Combinational grant decision for two requesters sharing one
//               RAM port. Computes the grants for the current cycle and the
//               next owner state, last owner and beat count.
// Ports       : state/last/cnt   in  current ownership context
//               a_req/b_req      in  access requests
//               a_gnt/b_gnt      out one-hot-or-zero grants
//               state_nxt/last_nxt/cnt_nxt  out  next ownership context
// Revision    : 1.0  initial release
// ============================================================================
module rr_arb2
  import bram_arbiter_pkg::*;
#(
  parameter int BURST_MAX = 4,
  parameter int CNT_W     = 3
) (
  input  arb_state_t       state,
  input  owner_t           last,
  input  logic [CNT_W-1:0] cnt,
  input  logic             a_req,
  input  logic             b_req,
  output logic             a_gnt,
  output logic             b_gnt,
  output arb_state_t       state_nxt,
  output owner_t           last_nxt,
  output logic [CNT_W-1:0] cnt_nxt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

  always_comb begin
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;

    case (state)
      IDLE: begin
        // On contention the requester that did not own the port last wins
        if (a_req && (!b_req || last == OWNER_B)) begin
          a_gnt     = 1'b1;
          state_nxt = OWN_A;
          last_nxt  = OWNER_A;
          cnt_nxt   = CNT_ONE;
        end else if (b_req) begin
          b_gnt     = 1'b1;
          state_nxt = OWN_B;
          last_nxt  = OWNER_B;
          cnt_nxt   = CNT_ONE;
        end
      end

      OWN_A: begin
        // Hand over in the same cycle so the port never idles on a switch
        if (b_req && (!a_req || cnt == CNT_MAX)) begin
          b_gnt     = 1'b1;
          state_nxt = OWN_B;
          last_nxt  = OWNER_B;
          cnt_nxt   = CNT_ONE;
        end else if (a_req) begin
          a_gnt = 1'b1;
          if (cnt != CNT_MAX) cnt_nxt = cnt + CNT_ONE;
        end else begin
          state_nxt = IDLE;
          last_nxt  = OWNER_A;
          cnt_nxt   = CNT_ONE;
        end
      end

      OWN_B: begin
        if (a_req && (!b_req || cnt == CNT_MAX)) begin
          a_gnt     = 1'b1;
          state_nxt = OWN_A;
          last_nxt  = OWNER_A;
          cnt_nxt   = CNT_ONE;
        end else if (b_req) begin
          b_gnt = 1'b1;
          if (cnt != CNT_MAX) cnt_nxt = cnt + CNT_ONE;
        end else begin
          state_nxt = IDLE;
          last_nxt  = OWNER_B;
          cnt_nxt   = CNT_ONE;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = CNT_ONE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bram_arbiter
// Description : Shares one single-port, read-first BRAM (1-cycle registered
//               read latency) between two requesters A and B with bounded
//               bursts. Accepted beats are registered onto the RAM port one
//               cycle later; read data returns to the issuing requester two
//               cycles after acceptance via an owner-tag pipeline.
// Ports       : clk, rst_n                   clock, async active-low reset
//               {a,b}_req/we/addr/wdata      requester command inputs
//               {a,b}_gnt                    combinational acceptance
//               {a,b}_rvalid/rdata           read return (rdata held)
//               ram_en/we/addr/di            registered RAM command
//               ram_dout                     RAM read data
// Revision    : 1.0  initial release
// ============================================================================
module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int CNT_W = cnt_width(BURST_MAX);

  arb_state_t       state, state_nxt;
  owner_t           last, last_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             arb_a_gnt, arb_b_gnt;
  logic             beat;
  logic             sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  rd_tag_t          tag1, tag2;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

  rr_arb2 #(
    .BURST_MAX (BURST_MAX),
    .CNT_W     (CNT_W)
  ) u_arb (
    .state     (state),
    .last      (last),
    .cnt       (cnt),
    .a_req     (a_req),
    .b_req     (b_req),
    .a_gnt     (arb_a_gnt),
    .b_gnt     (arb_b_gnt),
    .state_nxt (state_nxt),
    .last_nxt  (last_nxt),
    .cnt_nxt   (cnt_nxt)
  );

  // Grants are forced low for as long as reset is held
  assign a_gnt = arb_a_gnt & rst_n;
  assign b_gnt = arb_b_gnt & rst_n;
  assign beat  = a_gnt | b_gnt;

  // Mux the accepted requester's command onto the RAM port
  assign sel_we    = b_gnt ? b_we    : a_we;
  assign sel_addr  = b_gnt ? b_addr  : a_addr;
  assign sel_wdata = b_gnt ? b_wdata : a_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= OWNER_B;
      cnt       <= CNT_W'(1);
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_di    <= '0;
      tag1      <= '{valid: 1'b0, owner: OWNER_A};
      tag2      <= '{valid: 1'b0, owner: OWNER_A};
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state  <= state_nxt;
      last   <= last_nxt;
      cnt    <= cnt_nxt;
      ram_en <= beat;
      ram_we <= beat & sel_we;
      if (beat) begin
        ram_addr <= sel_addr;
        ram_di   <= sel_wdata;
      end
      // Stage 1 aligns with the RAM command, stage 2 with ram_dout
      tag1 <= '{valid: beat & ~sel_we, owner: (b_gnt ? OWNER_B : OWNER_A)};
      tag2 <= tag1;
      if (a_rvalid) a_rdata_q <= ram_dout;
      if (b_rvalid) b_rdata_q <= ram_dout;
    end
  end

  assign a_rvalid = tag2.valid && (tag2.owner == OWNER_A);
  assign b_rvalid = tag2.valid && (tag2.owner == OWNER_B);

  // Pass RAM data straight through on the return cycle, otherwise hold
  assign a_rdata = a_rvalid ? ram_dout : a_rdata_q;
  assign b_rdata = b_rvalid ? ram_dout : b_rdata_q;

endmodule
`default_nettype wire
